// File: rtl/dram_cmd_sequencer.sv
// DRAM request sequencer: splits a flat address into bank/row/col,
// tracks one open row per bank and paces precharge/activate/access.
//
// Ports:
//   clk, rst_b             clock, synchronous active-low reset
//   req_valid/req_ready    host request handshake (ready only in IDLE)
//   req_rw                 1 = write, 0 = read
//   req_addr               {bank, row, col}, col in the LSBs
//   req_wdata              write data
//   rsp_valid/rsp_rdata    one-cycle read response strobe and data
//   mem_bankid/rowid/colid registered array address
//   mem_rw, mem_din        array write enable and write data
//   mem_dout               array read data, one cycle after the address
module dram_cmd_sequencer #(
   parameter int NUM_OF_BANKS = 8,
   parameter int NUM_OF_ROWS  = 128,
   parameter int NUM_OF_COLS  = 8,
   parameter int DATA_WIDTH   = 1,
   parameter int T_RCD        = 2,
   parameter int T_RP         = 2,
   localparam int BW = $clog2(NUM_OF_BANKS),
   localparam int RW = $clog2(NUM_OF_ROWS),
   localparam int CW = $clog2(NUM_OF_COLS),
   localparam int AW = BW + RW + CW
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_rw,
   input  logic [AW-1:0]         req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [BW-1:0]         mem_bankid,
   output logic [RW-1:0]         mem_rowid,
   output logic [CW-1:0]         mem_colid,
   output logic                  mem_rw,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout
);

   localparam int TMAX = (T_RP > T_RCD) ? T_RP : T_RCD;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      ACT,
      ACCESS,
      RDWAIT
   } state_t;

   state_t                  state;
   logic [TW-1:0]           cnt;
   logic                    lat_rw;
   logic [BW-1:0]           lat_bank;
   logic [RW-1:0]           lat_row;
   logic [CW-1:0]           lat_col;
   logic [DATA_WIDTH-1:0]   lat_wdata;
   logic [NUM_OF_BANKS-1:0] open_q;
   logic [RW-1:0]           row_q [NUM_OF_BANKS];

   logic [BW-1:0] req_bank;
   logic [RW-1:0] req_row;
   logic [CW-1:0] req_col;

   assign req_bank  = req_addr[AW-1 -: BW];
   assign req_row   = req_addr[CW +: RW];
   assign req_col   = req_addr[CW-1:0];
   assign req_ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state      <= IDLE;
         cnt        <= '0;
         open_q     <= '0;
         lat_rw     <= 1'b0;
         lat_bank   <= '0;
         lat_row    <= '0;
         lat_col    <= '0;
         lat_wdata  <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         mem_rw     <= 1'b0;
         mem_bankid <= '0;
         mem_rowid  <= '0;
         mem_colid  <= '0;
         mem_din    <= '0;
      end else begin
         rsp_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_rw    <= req_rw;
                  lat_bank  <= req_bank;
                  lat_row   <= req_row;
                  lat_col   <= req_col;
                  lat_wdata <= req_wdata;
                  if (open_q[req_bank] &&
                      row_q[req_bank] == req_row) begin
                     // Row hit: go straight to the access cycle.
                     state      <= ACCESS;
                     mem_bankid <= req_bank;
                     mem_rowid  <= req_row;
                     mem_colid  <= req_col;
                     mem_rw     <= req_rw;
                     mem_din    <= req_wdata;
                  end else if (open_q[req_bank]) begin
                     state <= PRE;
                     cnt   <= TW'(T_RP - 1);
                  end else begin
                     state <= ACT;
                     cnt   <= TW'(T_RCD - 1);
                  end
               end
            end
            PRE: begin
               if (cnt == '0) begin
                  open_q[lat_bank] <= 1'b0;
                  state            <= ACT;
                  cnt              <= TW'(T_RCD - 1);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ACT: begin
               if (cnt == '0) begin
                  open_q[lat_bank] <= 1'b1;
                  row_q[lat_bank]  <= lat_row;
                  state            <= ACCESS;
                  mem_bankid       <= lat_bank;
                  mem_rowid        <= lat_row;
                  mem_colid        <= lat_col;
                  mem_rw           <= lat_rw;
                  mem_din          <= lat_wdata;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ACCESS: begin
               mem_rw <= 1'b0;
               state  <= lat_rw ? IDLE : RDWAIT;
            end
            RDWAIT: begin
               // Array output is valid this cycle for the read address.
               rsp_valid <= 1'b1;
               rsp_rdata <= mem_dout;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Directed bench for dram_cmd_sequencer with a behavioural array model
// and a read-data scoreboard.
module tb_dram_cmd_sequencer;

   localparam int T_RCD = 2;
   localparam int T_RP  = 2;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        req_valid;
   logic        req_ready;
   logic        req_rw;
   logic [12:0] req_addr;
   logic [0:0]  req_wdata;
   logic        rsp_valid;
   logic [0:0]  rsp_rdata;
   logic [2:0]  mem_bankid;
   logic [6:0]  mem_rowid;
   logic [2:0]  mem_colid;
   logic        mem_rw;
   logic [0:0]  mem_din;
   logic [0:0]  mem_dout;

   logic arr    [0:8191] = '{default: 1'b0};
   logic shadow [0:8191] = '{default: 1'b0};
   logic exp_q  [$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dram_cmd_sequencer #(
      .NUM_OF_BANKS(8),
      .NUM_OF_ROWS (128),
      .NUM_OF_COLS (8),
      .DATA_WIDTH  (1),
      .T_RCD       (T_RCD),
      .T_RP        (T_RP)
   ) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rw    (req_rw),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .mem_bankid(mem_bankid),
      .mem_rowid (mem_rowid),
      .mem_colid (mem_colid),
      .mem_rw    (mem_rw),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
   );

   // Bank array: write on mem_rw, registered read of the same address.
   always @(posedge clk) begin
      if (mem_rw === 1'b1)
         arr[{mem_bankid, mem_rowid, mem_colid}] <= mem_din[0];
      mem_dout[0] <= arr[{mem_bankid, mem_rowid, mem_colid}];
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [12:0] mk(input int b, input int r,
                                      input int c);
      return {b[2:0], r[6:0], c[2:0]};
   endfunction

   // Issue one request at a negedge; acc is the expected ACCESS cycle
   // counted from the accept edge. With hold set, req_valid stays high
   // and the request fields change while the sequencer is busy.
   task automatic do_req(input logic rw, input logic [12:0] addr,
                         input logic wd, input int acc, input bit hold);
      int last;
      last = rw ? acc + 1 : acc + 2;
      chk("ready_before", 32'(req_ready), 32'(1));
      req_valid = 1'b1;
      req_rw    = rw;
      req_addr  = addr;
      req_wdata = wd;
      if (rw) shadow[addr] = wd;
      else exp_q.push_back(shadow[addr]);
      @(posedge clk);
      #1;
      if (hold) begin
         req_rw    = ~rw;
         req_addr  = addr ^ 13'h1555;
         req_wdata = ~wd;
      end else begin
         req_valid = 1'b0;
      end
      for (int k = 1; k <= last; k++) begin
         @(negedge clk);
         chk($sformatf("mem_rw c%0d", k), 32'(mem_rw),
             32'(rw && k == acc));
         chk($sformatf("req_ready c%0d", k), 32'(req_ready),
             32'(k == last));
         chk($sformatf("rsp_valid c%0d", k), 32'(rsp_valid),
             32'(!rw && k == last));
         if (k == acc) begin
            chk("mem_bankid", 32'(mem_bankid), 32'(addr[12:10]));
            chk("mem_rowid", 32'(mem_rowid), 32'(addr[9:3]));
            chk("mem_colid", 32'(mem_colid), 32'(addr[2:0]));
            if (rw) chk("mem_din", 32'(mem_din), 32'(wd));
         end
         if (rsp_valid === 1'b1) begin
            chk("rsp_expected", 32'(exp_q.size() > 0), 32'(1));
            if (exp_q.size() > 0)
               chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_q.pop_front()));
         end
      end
      req_valid = 1'b0;
      if (!rw) begin
         chk("rsp_drained", 32'(exp_q.size()), 32'(0));
         exp_q.delete();
      end
   endtask

   initial begin
      rst_b     = 1'b0;
      req_valid = 1'b1;
      req_rw    = 1'b1;
      req_addr  = mk(1, 2, 3);
      req_wdata = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst rsp_rdata", 32'(rsp_rdata), 32'(0));
      chk("rst mem_rw", 32'(mem_rw), 32'(0));
      chk("rst mem_bankid", 32'(mem_bankid), 32'(0));
      chk("rst mem_rowid", 32'(mem_rowid), 32'(0));
      chk("rst mem_colid", 32'(mem_colid), 32'(0));
      chk("rst mem_din", 32'(mem_din), 32'(0));
      rst_b     = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("post_rst ready", 32'(req_ready), 32'(1));
      chk("post_rst mem_rw", 32'(mem_rw), 32'(0));

      // Closed bank, hit, conflict, hit after conflict.
      do_req(1'b1, mk(3, 5, 2), 1'b1, T_RCD + 1, 1'b0);
      do_req(1'b0, mk(3, 5, 2), 1'b0, 1, 1'b0);
      do_req(1'b0, mk(3, 9, 2), 1'b0, T_RP + T_RCD + 1, 1'b0);
      do_req(1'b0, mk(3, 9, 2), 1'b0, 1, 1'b0);

      // Bank independence.
      do_req(1'b1, mk(3, 5, 1), 1'b1, T_RP + T_RCD + 1, 1'b0);
      do_req(1'b1, mk(4, 7, 0), 1'b1, T_RCD + 1, 1'b0);
      do_req(1'b0, mk(3, 5, 1), 1'b0, 1, 1'b0);
      do_req(1'b0, mk(4, 7, 0), 1'b0, 1, 1'b0);
      do_req(1'b1, mk(4, 7, 3), 1'b1, 1, 1'b0);
      do_req(1'b0, mk(4, 7, 3), 1'b0, 1, 1'b0);

      // Held request with changing fields while busy.
      do_req(1'b0, mk(5, 1, 3), 1'b0, T_RCD + 1, 1'b1);
      do_req(1'b1, mk(5, 1, 6), 1'b1, 1, 1'b1);
      do_req(1'b0, mk(5, 1, 6), 1'b0, 1, 1'b0);

      // Reset while in ACT drops the write.
      chk("ract ready", 32'(req_ready), 32'(1));
      req_valid = 1'b1;
      req_rw    = 1'b1;
      req_addr  = mk(6, 3, 4);
      req_wdata = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("ract busy", 32'(req_ready), 32'(0));
      rst_b = 1'b0;
      @(negedge clk);
      chk("ract rst mem_rw", 32'(mem_rw), 32'(0));
      chk("ract rst ready", 32'(req_ready), 32'(1));
      rst_b = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("ract mem_rw %0d", k), 32'(mem_rw), 32'(0));
         chk($sformatf("ract rsp %0d", k), 32'(rsp_valid), 32'(0));
      end
      do_req(1'b0, mk(6, 3, 4), 1'b0, T_RCD + 1, 1'b0);
      do_req(1'b0, mk(3, 5, 1), 1'b0, T_RCD + 1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/dram_cmd_sequencer.md
# dram_cmd_sequencer

Request front-end that sits directly upstream of the DRAM bank array model and drives its `bankid`/`rowid`/`colid`/`rw`/`din` inputs and consumes its registered `dout`. Accepts one host request at a time over a valid/ready handshake and splits a flat address into bank/row/column. Tracks one open row per bank and inserts precharge and activate wait cycles (row miss/conflict) before the single access cycle. Read data is returned on a one-cycle response strobe.

## Interface
- `NUM_OF_BANKS`, 8, banks; BW = $clog2(NUM_OF_BANKS)
- `NUM_OF_ROWS`, 128, rows per bank; RW = $clog2(NUM_OF_ROWS)
- `NUM_OF_COLS`, 8, columns per row; CW = $clog2(NUM_OF_COLS)
- `DATA_WIDTH`, 1, data word width
- `T_RCD`, 2, activate-to-access cycles, legal ≥1
- `T_RP`, 2, precharge cycles, legal ≥1
- `clk` in 1: single clock, all logic on posedge
- `rst_b` in 1: synchronous, active-low reset
- `req_valid` in 1: request present
- `req_ready` out 1: sequencer can accept
- `req_rw` in 1: 1 = write, 0 = read
- `req_addr` in BW+RW+CW: {bank, row, col}, col in LSBs
- `req_wdata` in DATA_WIDTH: write data
- `rsp_valid` out 1: read data strobe, one cycle
- `rsp_rdata` out DATA_WIDTH: read data
- `mem_bankid` out BW, `mem_rowid` out RW, `mem_colid` out CW: array address
- `mem_rw` out 1: array write enable
- `mem_din` out DATA_WIDTH: array write data
- `mem_dout` in DATA_WIDTH: array read data, registered in the array one cycle after the address

## Operation
- States: IDLE, PRE, ACT, ACCESS, RDWAIT. `req_ready` = (state == IDLE), combinational from state.
- Accept when `req_valid && req_ready`: latch rw, bank, row, col, wdata; inputs are ignored until the next IDLE.
- Open-row table: per bank an `open` bit and RW-bit row. On accept, classify:
  - hit (open, row equal): IDLE→ACCESS.
  - closed: IDLE→ACT.
  - conflict (open, row differs): IDLE→PRE.
- PRE holds T_RP cycles, then clears that bank's `open` and enters ACT. ACT holds T_RCD cycles, then sets `open` and the row, and enters ACCESS. The down-counter reloads on each state entry.
- ACCESS lasts one cycle and presents the latched address. A write drives `mem_rw`=1 with `mem_din`=wdata, then goes to IDLE. A read keeps `mem_rw`=0, then goes to RDWAIT.
- RDWAIT lasts one cycle: capture `mem_dout` into `rsp_rdata` and set `rsp_valid`, then go to IDLE.
- `mem_rw` is 1 only in a write ACCESS cycle and 0 at all other times.
- `mem_*` address outputs and `mem_din` are registered and hold their last value outside ACCESS.
- Rows stay open after access. There is no auto-precharge and no refresh.
- Reset (`rst_b`=0 at posedge), in any state:
  - state→IDLE; all `open` bits cleared; counter cleared.
  - `rsp_valid`=0, `rsp_rdata`=0, `mem_rw`=0, `mem_bankid`/`mem_rowid`/`mem_colid`/`mem_din`=0.
  - An in-flight request is dropped with no write and no response.

## Timing
- Cycle 0 is the accept edge. ACCESS falls in:
  - cycle 1 on a hit;
  - cycle T_RCD+1 on a closed bank;
  - cycle T_RP+T_RCD+1 on a conflict.
- Read: `rsp_valid` is high in cycle ACCESS+2 for exactly one cycle. `rsp_rdata` holds that data until the next read response.
- `req_ready` is high again at ACCESS+1 for a write and at ACCESS+2 for a read (the same cycle as `rsp_valid`). A new request may be accepted in that cycle.
- Hit throughput: one write every 2 cycles, one read every 3 cycles.

## Test plan
- Reset: hold `rst_b`=0 for 2 cycles with `req_valid`=1 → all outputs 0, no accept; `req_ready`=1 in the first cycle after release.
- Closed-bank write: write addr bank3/row5/col2, wdata 1, T_RCD=2 → `mem_rw`=1 only in cycle 3, with `mem_bankid`=3, `mem_rowid`=5, `mem_colid`=2, `mem_din`=1; `req_ready` returns in cycle 4.
- Row hit read: read bank3/row5/col2 → ACCESS in cycle 1; `rsp_valid`=1 with `rsp_rdata`=1 in cycle 3 only.
- Conflict read: read bank3/row9/col2 with T_RP=2, T_RCD=2 → ACCESS in cycle 5, `rsp_valid` in cycle 7, data 0; a following read of row9 is a hit.
- Bank independence: open row5 on bank3, then row7 on bank4, then read bank3/row5 → the last read is a hit (ACCESS in cycle 1).
- Stall/reset mid-flight: keep `req_valid`=1 and change `req_addr` during ACT → no second accept. Assert reset in ACT → no `mem_rw` pulse, no `rsp_valid`; the previously open row takes the closed-bank path afterwards.
